// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_ctrl
//  Purpose  : Read-side controller of an asynchronous FIFO. Keeps the binary
//             and Gray read pointers, issues one memory read per word, and
//             presents the word through a valid/ready output register.
//  Ports    : clk, reset       - read-domain clock, async active-high reset
//             wptr_gray_sync   - write pointer (Gray), synchronized into clk
//             mem_ren/raddr    - memory read request
//             mem_rdata        - memory data, valid one cycle after mem_ren
//             rd_valid/ready   - output handshake; rd_data holds the word
//             rptr_gray        - registered Gray read pointer for write domain
//             empty            - no unread words in memory
//             rd_level         - words in memory (0 unless FIFO_RD_LEVEL_EN)
//  Options  : FIFO_RD_LEVEL_EN - enables the registered rd_level computation
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W:0]   wptr_gray_sync,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   rptr_gray,
   output logic              empty,
   output logic [ADDR_W:0]   rd_level
);

   localparam int c_PTR_W = ADDR_W + 1;

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_FETCH = 2'd1;
   localparam logic [1:0] c_S_HOLD  = 2'd2;

   logic [1:0]          r_state;
   logic [c_PTR_W-1:0]  r_rbin;
   logic [c_PTR_W-1:0]  w_rbin_next;
   logic [c_PTR_W-1:0]  r_rptr_gray;
   logic                r_rd_valid;
   logic [DATA_W-1:0]   r_rd_data;
   logic                w_empty;
   logic                w_hs;
   logic                w_issue;

   assign w_empty = (r_rptr_gray == wptr_gray_sync);
   assign w_hs    = r_rd_valid & rd_ready;

   // A read is issued from IDLE whenever data exists, or from HOLD when the
   // held word is accepted and more data exists (back-to-back refetch).
   always_comb begin
      w_issue = 1'b0;
      case (r_state)
         c_S_IDLE: w_issue = ~w_empty;
         c_S_HOLD: w_issue = w_hs & ~w_empty;
         default:  w_issue = 1'b0;
      endcase
   end

   assign w_rbin_next = r_rbin + {{ADDR_W{1'b0}}, w_issue};

   // Gate with reset so no request escapes while the block is held in reset
   // and the write pointer happens to differ from the cleared read pointer.
   assign mem_ren   = w_issue & ~reset;
   assign mem_raddr = r_rbin[ADDR_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_S_IDLE;
         r_rbin      <= '0;
         r_rptr_gray <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_rbin      <= w_rbin_next;
         r_rptr_gray <= (w_rbin_next >> 1) ^ w_rbin_next;
         case (r_state)
            c_S_IDLE: begin
               if (w_issue) r_state <= c_S_FETCH;
            end
            c_S_FETCH: begin
               r_rd_data  <= mem_rdata;
               r_rd_valid <= 1'b1;
               r_state    <= c_S_HOLD;
            end
            c_S_HOLD: begin
               if (w_hs) begin
                  r_rd_valid <= 1'b0;
                  r_state    <= w_issue ? c_S_FETCH : c_S_IDLE;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign rptr_gray = r_rptr_gray;
   assign empty     = w_empty;

`ifdef FIFO_RD_LEVEL_EN
   logic [c_PTR_W-1:0] w_wbin;
   logic [c_PTR_W-1:0] r_rd_level;

   // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
   for (genvar i = 0; i < c_PTR_W; i++) begin : g_g2b
      assign w_wbin[i] = ^(wptr_gray_sync >> i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rd_level <= '0;
      else       r_rd_level <= w_wbin - r_rbin;
   end

   assign rd_level = r_rd_level;
`else
   assign rd_level = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_ctrl
//  Purpose  : Self-checking bench for fifo_rd_ctrl. A transaction-level model
//             counts words written and words issued, and derives empty,
//             pointer, request, valid timing and data from those counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW:0]   wptr_gray_sync;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic [AW:0]   rptr_gray;
   logic          empty;
   logic [AW:0]   rd_level;

   fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .wptr_gray_sync (wptr_gray_sync),
      .mem_ren        (mem_ren),
      .mem_raddr      (mem_raddr),
      .mem_rdata      (mem_rdata),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_data        (rd_data),
      .rptr_gray      (rptr_gray),
      .empty          (empty),
      .rd_level       (rd_level)
   );

   always #5 clk = ~clk;

   // Memory behind the controller: registered read, data one cycle later.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

   // Model state: absolute counts of words written and reads issued.
   int            wcnt, icnt, cyc, issue_cyc;
   bit            pending;
   logic [DW-1:0] dq[$];
   logic [AW:0]   level_exp;
   int            n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AW:0] gray(input int v);
      logic [AW:0] b;
      b = v[AW:0];
      return b ^ (b >> 1);
   endfunction

   // Write up to n words, never overwriting a word not yet read from memory.
   task automatic put(input int n);
      for (int i = 0; i < n; i++) begin
         if (wcnt - icnt < DEPTH) begin
            mem[wcnt % DEPTH] = DW'($urandom);
            wcnt++;
         end
      end
      wptr_gray_sync = gray(wcnt);
   endtask

   // Compare the DUT against the model for the current cycle, then advance
   // the model over the coming clock edge.
   task automatic eval();
      bit exp_empty, exp_valid, hs, exp_ren;
      exp_empty = (wcnt == icnt);
      exp_valid = pending && (cyc - issue_cyc >= 2);
      hs        = exp_valid && rd_ready;
      exp_ren   = !exp_empty && (!pending || hs);
      chk("empty",     32'(empty),     32'(exp_empty));
      chk("rd_valid",  32'(rd_valid),  32'(exp_valid));
      chk("mem_ren",   32'(mem_ren),   32'(exp_ren));
      chk("rptr_gray", 32'(rptr_gray), 32'(gray(icnt)));
`ifdef FIFO_RD_LEVEL_EN
      chk("rd_level",  32'(rd_level),  32'(level_exp));
`else
      chk("rd_level",  32'(rd_level),  32'd0);
`endif
      if (exp_ren)   chk("mem_raddr", 32'(mem_raddr), icnt % DEPTH);
      if (exp_valid) chk("rd_data",   32'(rd_data),   32'(dq[0]));
      level_exp = (AW+1)'(wcnt - icnt);
      if (hs) begin
         void'(dq.pop_front());
         pending = 1'b0;
      end
      if (exp_ren) begin
         dq.push_back(mem[icnt % DEPTH]);
         icnt++;
         pending   = 1'b1;
         issue_cyc = cyc;
      end
      cyc++;
   endtask

   task automatic step(input bit rdy, input int nw);
      @(negedge clk);
      rd_ready = rdy;
      put(nw);
      #1;
      eval();
   endtask

   task automatic model_reset();
      wcnt = 0; icnt = 0; pending = 1'b0; level_exp = '0;
      dq.delete();
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; issue_cyc = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      model_reset();
      reset = 1'b1; rd_ready = 1'b0; wptr_gray_sync = '0;
      #1;
      chk("rst_rd_valid",  32'(rd_valid),  32'd0);
      chk("rst_rd_data",   32'(rd_data),   32'd0);
      chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
      chk("rst_empty",     32'(empty),     32'd1);
      // Non-empty pointer while in reset must not produce a request.
      @(negedge clk);
      wptr_gray_sync = gray(1);
      #1;
      chk("rst_mem_ren", 32'(mem_ren), 32'd0);
      @(negedge clk);
      wptr_gray_sync = '0;
      reset = 1'b0;
      #1;
      eval();

      // Idle empty FIFO.
      for (int i = 0; i < 4; i++) step(1'b1, 0);
      // Single word with consumer ready.
      step(1'b1, 1);
      for (int i = 0; i < 6; i++) step(1'b1, 0);
      // Full memory drained at full rate.
      step(1'b1, DEPTH);
      for (int i = 0; i < 2*DEPTH + 6; i++) step(1'b1, 0);
      // Backpressure while holding a word.
      step(1'b0, 3);
      for (int i = 0; i < 7; i++) step(1'b0, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 0);
      // Randomized traffic; pointers wrap many times.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 15) == 0) ? DEPTH : $urandom_range(0, 2));
      for (int i = 0; i < 2*DEPTH + 6; i++) step(1'b1, 0);

      // Reset while a word is held, then recover with four words pending.
      step(1'b0, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 0);
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      chk("arst_rd_data",  32'(rd_data),  32'd0);
      chk("arst_mem_ren",  32'(mem_ren),  32'd0);
      @(negedge clk);
      model_reset();
      put(4);
      reset = 1'b0;
      rd_ready = 1'b1;
      #1;
      eval();
      for (int i = 0; i < 14; i++) step(1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 4, memory address width; pointer width is ADDR_W+1; depth is 2^ADDR_W.
- DATA_W, 8, read data width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, read-domain clock.
- reset, input, 1, asynchronous, active-high.
- wptr_gray_sync, input, ADDR_W+1, write pointer in Gray code, already synchronized into clk.
- mem_ren, output, 1, memory read enable.
- mem_raddr, output, ADDR_W, memory read address.
- mem_rdata, input, DATA_W, memory data, valid one cycle after mem_ren.
- rd_valid, output, 1, rd_data holds a word.
- rd_ready, input, 1, consumer accepts the word.
- rd_data, output, DATA_W, output word register.
- rptr_gray, output, ADDR_W+1, registered read pointer in Gray code, for the write domain.
- empty, output, 1, no unread words in memory.
- rd_level, output, ADDR_W+1, words in memory (see Configuration).
REQ-003 Reset SHALL be reset, asynchronous, active-high; clock SHALL be clk.

Function
REQ-004 The block SHALL keep a binary read pointer rbin of width ADDR_W+1, with mem_raddr = rbin[ADDR_W-1:0].
REQ-005 rptr_gray SHALL be registered and updated in the same cycle as rbin, equal to (rbin_next >> 1) ^ rbin_next.
REQ-006 empty SHALL be combinational: 1 exactly when rptr_gray == wptr_gray_sync.
REQ-007 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-008 In IDLE with empty=0, the FSM SHALL assert mem_ren, increment rbin by 1 (modulo 2^(ADDR_W+1)), and go to FETCH. In IDLE with empty=1, it SHALL stay in IDLE with mem_ren=0.
REQ-009 FETCH SHALL last exactly one cycle: load rd_data from mem_rdata, set rd_valid=1, and go to HOLD.
REQ-010 In HOLD, a handshake (rd_valid & rd_ready) SHALL:
- clear rd_valid on the next edge;
- if empty=0 in the same cycle, assert mem_ren, increment rbin, and go to FETCH;
- otherwise go to IDLE.
REQ-011 In HOLD with rd_ready=0, rd_data and rd_valid SHALL hold stable and mem_ren SHALL be 0.
REQ-012 mem_ren SHALL be asserted only in the cases given in REQ-008 and REQ-010; a read SHALL never be issued while empty=1.
REQ-013 Latency from empty falling in IDLE to rd_valid=1 SHALL be 2 cycles.
REQ-014 Maximum throughput SHALL be one word per 2 cycles; rd_valid is low during every FETCH cycle.
REQ-015 Wrap-around: rbin SHALL roll over from 2^(ADDR_W+1)-1 to 0 with no gap or stall, and mem_raddr SHALL roll over from 2^ADDR_W-1 to 0.
REQ-016 A full memory (pointers differ only in the two MSBs of the Gray code) SHALL be readable for exactly 2^ADDR_W words.
REQ-017 rd_ready while rd_valid=0 SHALL be ignored.
REQ-018 A wptr_gray_sync change in the same cycle as a handshake SHALL take effect through that cycle's empty value only.

Reset
REQ-019 On reset, all of the following SHALL clear asynchronously: rbin=0, rptr_gray=0, FSM=IDLE, rd_valid=0, rd_data=0, rd_level=0.
REQ-020 mem_ren SHALL be 0 while reset is high.
REQ-021 Reset during FETCH or HOLD SHALL discard the in-flight or held word with no handshake.
REQ-022 The write domain SHALL be reset in the same event; recovery of pointer consistency is system-level.

Configuration
REQ-023 Macro FIFO_RD_LEVEL_EN defined: rd_level SHALL be a register updated every cycle with (gray2bin(wptr_gray_sync) - rbin) modulo 2^(ADDR_W+1).
REQ-024 Macro FIFO_RD_LEVEL_EN defined: rd_level SHALL range from 0 to 2^ADDR_W.
REQ-025 Macro FIFO_RD_LEVEL_EN undefined: the rd_level port SHALL remain and be tied to 0, with no conversion logic instantiated.

Verification
REQ-026 Reset, then drive wptr_gray_sync=00000 -> empty=1, mem_ren never asserted, rd_valid=0, rptr_gray=00000.
REQ-027 Drive wptr_gray_sync=00001 (one word) with rd_ready=1 -> mem_ren=1 with mem_raddr=0, rd_valid=1 two cycles later, handshake completes, FSM returns to IDLE, empty=1, rptr_gray=00001.
REQ-028 Load a full memory (wptr_gray_sync=11000, rbin=0), hold rd_ready=1 -> exactly 16 words read at addresses 0..15, one every 2 cycles, then empty=1 with rptr_gray=11000.
REQ-029 Backpressure: rd_ready=0 for 5 cycles in HOLD -> rd_data and rd_valid stable, mem_ren=0; rd_ready=1 -> next fetch issues in the same cycle.
REQ-030 Wrap: start with rbin=30, write pointer 3 words ahead -> addresses 14, 15, 0 read; rptr_gray sequence 10001, 10000, 00000, 00001.
REQ-031 Assert reset in HOLD with rd_data=0xA5 -> rd_valid=0 and rd_data=0 immediately; with FIFO_RD_LEVEL_EN and wptr_gray_sync=00110, rd_level=4 one cycle after reset release.
